// File: rtl/mlx90640_subpage_scanner.sv
// mlx90640_subpage_scanner: arithmetic MLX90640 subpage lookup plus a valid/ready scanner
// that streams every pixel address of a requested subpage.
module mlx90640_subpage_scanner #(
   parameter int COLS = 32,
   parameter int ROWS = 24,
   localparam int DEPTH = COLS * ROWS,
   localparam int ADDRW = $clog2(DEPTH),
   localparam int CW = $clog2(COLS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             start_subpage,
   input  logic             start_mode,
   output logic             busy,
   output logic             done,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [ADDRW-1:0] m_addr,
   output logic             m_last,
   input  logic [ADDRW-1:0] lk_addr,
   input  logic             lk_mode,
   output logic             lk_subpage
);
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
   localparam logic [ADDRW-1:0] END_IDX = ADDRW'(DEPTH - 1);
   state_t state;
   logic sub, mode, adv, hit;
   logic [ADDRW-1:0] idx, last_idx;
   function automatic logic sp(input logic [ADDRW-1:0] a, input logic md);
      return md ? a[CW] : a[CW] ^ a[0];
   endfunction
   // last matching pixel is in the final row, or the row before it when that row belongs to the other subpage
   always_comb begin
      adv = !m_valid || m_ready;
      hit = sp(idx, mode) == sub;
      last_idx = mode ? ((logic'((ROWS - 1) % 2) == sub) ? END_IDX : ADDRW'(DEPTH - 1 - COLS))
                      : ((sp(END_IDX, 1'b0) == sub) ? END_IDX : ADDRW'(DEPTH - 2));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         m_valid <= 1'b0;
         m_last <= 1'b0;
         m_addr <= '0;
         lk_subpage <= 1'b0;
         idx <= '0;
         sub <= 1'b0;
         mode <= 1'b0;
      end else begin
         done <= 1'b0;
         lk_subpage <= sp(lk_addr, lk_mode);
         case (state)
            IDLE: if (start) begin
               sub <= start_subpage;
               mode <= start_mode;
               idx <= '0;
               busy <= 1'b1;
               state <= SCAN;
            end
            SCAN: if (adv) begin
               m_valid <= hit;
               if (hit) begin
                  m_addr <= idx;
                  m_last <= idx == last_idx;
               end
               idx <= idx + 1'b1;
               if (idx == END_IDX) state <= DRAIN;
            end
            DRAIN: if (adv) begin
               m_valid <= 1'b0;
               m_last <= 1'b0;
               busy <= 1'b0;
               done <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mlx90640_subpage_scanner.sv
// tb_mlx90640_subpage_scanner: scoreboard bench; expected beats come from a row/column
// reference model and are checked by an independent monitor.
module tb_mlx90640_subpage_scanner;
   localparam int COLS = 32;
   localparam int ROWS = 24;
   localparam int DEPTH = COLS * ROWS;
   localparam int ADDRW = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b1;
   logic start_subpage = 1'b0;
   logic start_mode = 1'b0;
   logic busy, done, m_valid, m_last, lk_subpage;
   logic m_ready = 1'b1;
   logic [ADDRW-1:0] m_addr;
   logic [ADDRW-1:0] lk_addr = '0;
   logic lk_mode = 1'b0;

   typedef struct {int addr; bit last;} beat_t;
   beat_t sb[$];
   int n_cmp = 0, n_bad = 0;
   int beats = 0, last_cnt = 0, done_cnt = 0;
   bit bp_en = 1'b0;
   bit fin = 1'b0;

   mlx90640_subpage_scanner #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_subpage(start_subpage),
      .start_mode(start_mode), .busy(busy), .done(done), .m_valid(m_valid),
      .m_ready(m_ready), .m_addr(m_addr), .m_last(m_last), .lk_addr(lk_addr),
      .lk_mode(lk_mode), .lk_subpage(lk_subpage)
   );

   always #5 clk = ~clk;

   function automatic bit ref_sp(input int a, input bit md);
      int r, c;
      r = a / COLS;
      c = a % COLS;
      return bit'(md ? r % 2 : (r + c) % 2);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_model(input bit sp, input bit md);
      int lastv = -1;
      for (int a = 0; a < DEPTH; a++) if (ref_sp(a, md) == sp) lastv = a;
      for (int a = 0; a < DEPTH; a++) if (ref_sp(a, md) == sp) sb.push_back('{a, a == lastv});
   endtask

   // monitor: beats, stall stability, done pulses, lookup port
   bit stall_q = 1'b0, done_q = 1'b0, lk_ok = 1'b0, lk_exp = 1'b0, hold_last = 1'b0;
   int hold_addr = 0;
   always @(negedge clk) begin
      beat_t e;
      if (m_valid && m_ready) begin
         beats++;
         if (m_last) last_cnt++;
         if (sb.size() == 0) chk("unexpected_beat", int'(m_addr), -1);
         else begin
            e = sb.pop_front();
            chk("beat_addr", int'(m_addr), e.addr);
            chk("beat_last", int'(m_last), int'(e.last));
         end
      end
      if (stall_q) begin
         chk("stall_valid", int'(m_valid), 1);
         chk("stall_addr", int'(m_addr), hold_addr);
         chk("stall_last", int'(m_last), int'(hold_last));
      end
      stall_q = m_valid && !m_ready && rst_n;
      hold_addr = int'(m_addr);
      hold_last = m_last;
      if (lk_ok) chk("lk_subpage", int'(lk_subpage), int'(lk_exp));
      lk_exp = rst_n ? ref_sp(int'(lk_addr), lk_mode) : 1'b0;
      lk_ok = 1'b1;
      if (done) begin
         done_cnt++;
         chk("done_one_cycle", int'(done_q), 0);
      end
      done_q = done;
   end

   initial begin
      while (!fin) begin
         @(posedge clk);
         #1 m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      @(posedge rst_n);
      @(posedge clk); #1 lk_addr = 10'd33; lk_mode = 1'b0;
      @(posedge clk); #1 lk_addr = 10'd33; lk_mode = 1'b1;
      @(posedge clk); #1 lk_addr = 10'd1;  lk_mode = 1'b0;
      while (!fin) begin
         @(posedge clk);
         #1 lk_addr = ADDRW'($urandom_range(0, DEPTH - 1));
         lk_mode = 1'($urandom_range(0, 1));
      end
   end

   task automatic run_scan(input bit sp, input bit md, input bit bp, input bit chk_lat);
      int n, k, d0, l0;
      k = 0;
      while (busy && k < 5000) begin @(posedge clk); k++; end
      @(posedge clk); #1;
      push_model(sp, md);
      d0 = done_cnt;
      l0 = last_cnt;
      bp_en = bp;
      start = 1'b1; start_subpage = sp; start_mode = md;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", int'(busy), 1);
      n = 0;
      while (n < 20000) begin
         @(negedge clk);
         n++;
         if (done) break;
      end
      chk("done_seen", int'(done), 1);
      if (chk_lat) chk("start_to_done", n, DEPTH + 1);
      @(posedge clk); #1;
      chk("done_count", done_cnt, d0 + 1);
      chk("last_count", last_cnt, l0 + 1);
      chk("sb_drained", sb.size(), 0);
      chk("busy_after_done", int'(busy), 0);
   endtask

   task automatic abort_scan();
      int k, d0, b0;
      @(posedge clk); #1;
      push_model(1'b0, 1'b0);
      d0 = done_cnt;
      b0 = beats;
      bp_en = 1'b0;
      start = 1'b1; start_subpage = 1'b0; start_mode = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      k = 0;
      while (beats < b0 + 50 && k < 5000) begin @(posedge clk); #1; k++; end
      start = 1'b1; start_subpage = 1'b1; start_mode = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_ignores_start", int'(busy), 1);
      k = 0;
      while (beats < b0 + 100 && k < 5000) begin @(posedge clk); #1; k++; end
      chk("reached_beat_100", int'(beats >= b0 + 100), 1);
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(m_valid), 0);
      repeat (5) @(posedge clk);
      #1 chk("abort_no_done", done_cnt, d0);
      sb.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_lk", int'(lk_subpage), 0);
      #1 rst_n = 1'b1; start = 1'b0;
      run_scan(1'b0, 1'b0, 1'b0, 1'b1);
      run_scan(1'b1, 1'b0, 1'b1, 1'b0);
      run_scan(1'b0, 1'b1, 1'b0, 1'b1);
      run_scan(1'b1, 1'b1, 1'b1, 1'b0);
      abort_scan();
      run_scan(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         bit sp, md, bp;
         sp = 1'($urandom_range(0, 1));
         md = 1'($urandom_range(0, 1));
         bp = 1'($urandom_range(0, 1));
         run_scan(sp, md, bp, !bp);
      end
      fin = 1'b1;
      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
